// File: rtl/tick_divider_chain_pkg.sv
// Shared defaults and elaboration helpers for the tick divider chain.
package tick_divider_chain_pkg;

    localparam int TICKDIV_BASE_W  = 22;
    localparam int TICKDIV_STAGE_W = 8;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Width of a stage index that can also encode one out-of-range value.
    function automatic int sel_w(input int num_stages);
        int w;
        w = clog2(num_stages + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/tick_divider_chain_if.sv
// Control/status bundle of the tick divider chain; divisor-write fields exist only
// when TICKDIV_RUNTIME_LOAD_EN is defined.
interface tick_divider_chain_if
    import tick_divider_chain_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int BASE_W     = TICKDIV_BASE_W
);
    logic                  run;
    logic                  clear;
    logic [NUM_STAGES-1:0] tick;
    logic [NUM_STAGES-1:0] level;

`ifdef TICKDIV_RUNTIME_LOAD_EN
    localparam int SEL_W = sel_w(NUM_STAGES);

    logic              div_we;
    logic [SEL_W-1:0]  div_sel;
    logic [BASE_W-1:0] div_wdata;

    modport master (
        output run, clear, div_we, div_sel, div_wdata,
        input  tick, level
    );

    modport slave (
        input  run, clear, div_we, div_sel, div_wdata,
        output tick, level
    );
`else
    modport master (
        output run, clear,
        input  tick, level
    );

    modport slave (
        input  run, clear,
        output tick, level
    );
`endif

endinterface

// File: rtl/tick_divider_chain_stage.sv
// One clock-enable divider: counts en_in pulses, emits a registered one-cycle tick
// every divisor pulses and toggles level with it. Divisor 0 behaves as 1.
module tick_divider_chain_stage #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_in,
    input  logic [CNT_W-1:0] divisor,
    input  logic             clr,
    input  logic             load,
    output logic             tick,
    output logic             level
);
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] last_cnt;

    assign last_cnt = (divisor == '0) ? '0 : divisor - CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt   <= '0;
            tick  <= 1'b0;
            level <= 1'b0;
        end else if (load) begin
            // New divisor restarts the period; level keeps its phase.
            cnt  <= '0;
            tick <= 1'b0;
        end else if (en_in) begin
            if (cnt == last_cnt) begin
                cnt   <= '0;
                tick  <= 1'b1;
                level <= ~level;
            end else begin
                cnt  <= cnt + CNT_W'(1);
                tick <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/tick_divider_chain.sv
// Purpose: cascade of clock-enable dividers giving tick strobes and 50% levels per stage.
// Latency: tick[0] D0 cycles after restart, each later stage +1 clk after its source tick.
// Backpressure: none; run=0 pauses everything. TICKDIV_RUNTIME_LOAD_EN adds divisor writes.
module tick_divider_chain
    import tick_divider_chain_pkg::*;
#(
    parameter int          NUM_STAGES = 3,
    parameter int          BASE_W     = TICKDIV_BASE_W,
    parameter int unsigned BASE_DIV   = 390625,
    parameter int          STAGE_W    = TICKDIV_STAGE_W,
    parameter logic [((NUM_STAGES > 1) ? (NUM_STAGES - 1) : 1)*STAGE_W-1:0]
                           STAGE_DIVS = {8'd2, 8'd128}
) (
    input  logic                clk,
    input  logic                rst,
    tick_divider_chain_if.slave bus
);
`ifdef TICKDIV_RUNTIME_LOAD_EN
    localparam int SEL_W = sel_w(NUM_STAGES);
`endif

    logic [NUM_STAGES-1:0] tick_w;
    logic [NUM_STAGES-1:0] level_w;

    genvar k;
    generate
        for (k = 0; k < NUM_STAGES; k++) begin : g_stage
            localparam int CNT_W = (k == 0) ? BASE_W : STAGE_W;
            localparam int SLICE = (k == 0) ? 0 : k - 1;
            localparam logic [STAGE_W-1:0] STAGE_DEF = STAGE_DIVS[SLICE*STAGE_W +: STAGE_W];
            localparam logic [CNT_W-1:0] DEF_DIV =
                (k == 0) ? CNT_W'(BASE_DIV) : CNT_W'(STAGE_DEF);

            logic [CNT_W-1:0] divisor;
            logic             load;
            logic             en;

`ifdef TICKDIV_RUNTIME_LOAD_EN
            // Out-of-range selects match no stage, so such writes fall away.
            assign load = bus.div_we && (bus.div_sel == SEL_W'(k));

            always_ff @(posedge clk) begin
                if (rst) begin
                    divisor <= DEF_DIV;
                end else if (load && !bus.clear) begin
                    divisor <= bus.div_wdata[CNT_W-1:0];
                end
            end
`else
            assign load    = 1'b0;
            assign divisor = DEF_DIV;
`endif

            assign en = bus.run & ((k == 0) | tick_w[SLICE]);

            tick_divider_chain_stage #(
                .CNT_W(CNT_W)
            ) u_stage (
                .clk    (clk),
                .rst    (rst),
                .en_in  (en),
                .divisor(divisor),
                .clr    (bus.clear),
                .load   (load),
                .tick   (tick_w[k]),
                .level  (level_w[k])
            );
        end
    endgenerate

    assign bus.tick  = tick_w;
    assign bus.level = level_w;

endmodule
